nested_isqrt_fsm: RTL and testbench

NESTED_ISQRT_FSM -- requirements
Module: nested_isqrt_fsm

---
 rtl/nested_isqrt_fsm.sv | 88 ++++++++
 tb/tb_nested_isqrt_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nested_isqrt_fsm.sv
// nested_isqrt_fsm: res = isqrt(a[0] + isqrt(a[1] + ... isqrt(a[N-1]))) over one shared isqrt unit.
// Define NESTED_ISQRT_SAT_EN to saturate a[idx]+y on carry-out instead of wrapping.
module nested_isqrt_fsm #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic [N*W-1:0] arg,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [W-1:0]   res,
    output logic           isqrt_x_vld,
    output logic [W-1:0]   isqrt_x,
    input  logic           isqrt_y_vld,
    input  logic [W/2-1:0] isqrt_y
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W/2-1:0] y_q, y_d;
    logic [N*W-1:0] a_q, a_d;
    logic [W-1:0]   term;
    logic [W-1:0]   y_ext;
    logic [W-1:0]   add_v;

    assign term  = a_q[idx_q*W +: W];
    assign y_ext = {{(W/2){1'b0}}, y_q};

`ifdef NESTED_ISQRT_SAT_EN
    logic [W:0] sum;
    assign sum   = {1'b0, term} + {1'b0, y_ext};
    assign add_v = sum[W] ? '1 : sum[W-1:0];
`else
    assign add_v = term + y_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        y_d     = y_q;
        a_d     = a_q;
        unique case (state_q)
            IDLE: if (arg_vld) begin
                a_d     = arg;
                idx_d   = LAST;
                state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (isqrt_y_vld) begin
                y_d     = isqrt_y;
                idx_d   = idx_q == '0 ? idx_q : idx_q - 1'b1;
                state_d = idx_q == '0 ? DONE : ISSUE;
            end
            DONE: state_d = res_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // The innermost term enters the isqrt unit unmodified; every outer one adds the previous root.
    always_comb begin
        arg_rdy     = state_q == IDLE;
        isqrt_x_vld = state_q == ISSUE;
        isqrt_x     = state_q == ISSUE ? (idx_q == LAST ? term : add_v) : '0;
        res_vld     = state_q == DONE;
        res         = y_ext;
    end
endmodule

// File: tb/tb_nested_isqrt_fsm.sv
// tb_nested_isqrt_fsm: scoreboard bench over N=3, N=2 and N=1 instances with a 4-cycle isqrt model.
module tb_nested_isqrt_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  arg_vld, arg_rdy, res_vld, res_rdy, x_vld, y_vld;
    logic [95:0] arg [3];
    logic [31:0] res [3];
    logic [31:0] x   [3];
    logic [15:0] y   [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];
    logic [31:0] req_q [$];

    function automatic logic [15:0] isqrt_f(input logic [31:0] v);
        logic [15:0] r = '0;
        logic [15:0] t;
        logic [31:0] tt;
        for (int b = 15; b >= 0; b--) begin
            t  = r | (16'd1 << b);
            tt = {16'd0, t} * {16'd0, t};
            if (tt <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_nested(input int n, input logic [95:0] a);
        logic [32:0] s;
        logic [15:0] yv = '0;
        for (int i = n - 1; i >= 0; i--) begin
            s = {1'b0, a[i*32 +: 32]} + (i == n - 1 ? 33'd0 : {17'd0, yv});
`ifdef NESTED_ISQRT_SAT_EN
            if (s[32]) s[31:0] = '1;
`endif
            yv = isqrt_f(s[31:0]);
        end
        return yv;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NG = 3 - g;
        logic [3:0]  vp;
        logic [15:0] yp [4];
        nested_isqrt_fsm #(.N(NG), .W(32)) dut (
            .clk(clk), .rst(rst),
            .arg_vld(arg_vld[g]), .arg_rdy(arg_rdy[g]), .arg(arg[g][NG*32-1:0]),
            .res_vld(res_vld[g]), .res_rdy(res_rdy[g]), .res(res[g]),
            .isqrt_x_vld(x_vld[g]), .isqrt_x(x[g]),
            .isqrt_y_vld(y_vld[g]), .isqrt_y(y[g])
        );
        always @(posedge clk) begin
            if (rst) vp <= '0;
            else vp <= {vp[2:0], x_vld[g]};
            yp[0] <= isqrt_f(x[g]);
            yp[1] <= yp[0];
            yp[2] <= yp[1];
            yp[3] <= yp[2];
        end
        assign y_vld[g] = vp[3];
        assign y[g]     = yp[3];
    end

    always @(posedge clk) if (x_vld[0]) req_q.push_back(x[0]);
    always @(negedge clk) if (!rst) chk("x_idle", x[0] & {32{~x_vld[0]}}, 0);

    task automatic start_op(input int g, input logic [95:0] a, input bit push, output int acc);
        int t = 0;
        arg[g]     = a;
        arg_vld[g] = 1'b1;
        while (!arg_rdy[g] && t < 50) begin step(); t++; end
        chk("accept_rdy", arg_rdy[g], 1);
        acc = cyc;
        if (push) exp_q.push_back(ref_nested(3 - g, a));
        step();
        arg_vld[g] = 1'b0;
        arg[g]     = '1;
    endtask

    task automatic finish_op(input int g, input int acc, input int hold);
        int t = 0;
        logic [31:0] r;
        while (!res_vld[g] && t < 200) begin step(); t++; end
        chk("res_vld", res_vld[g], 1);
        chk("latency", cyc - acc, (3 - g) * 5 + 1);
        r = res[g];
        if (hold > 0) arg_vld[g] = 1'b1;
        repeat (hold) begin
            step();
            chk("hold_vld", res_vld[g], 1);
            chk("hold_res", res[g], r);
            chk("hold_rdy", arg_rdy[g], 0);
        end
        res_rdy[g] = 1'b1;
        if (exp_q.size() == 0) chk("sb_empty", 0, 1);
        else chk("res", res[g], exp_q.pop_front());
        step();
        res_rdy[g] = 1'b0;
        arg_vld[g] = 1'b0;
        chk("post_vld", res_vld[g], 0);
        chk("post_rdy", arg_rdy[g], 1);
    endtask

    initial begin
        int acc;
        int t;
        int nv;
        arg_vld = '0;
        res_rdy = '0;
        for (int i = 0; i < 3; i++) arg[i] = '0;
        repeat (3) step();
        chk("rst_res_vld", res_vld[0], 0);
        chk("rst_x_vld", x_vld[0], 0);
        chk("rst_res", res[0], 0);
        rst = 1'b0;
        step();
        chk("rst_arg_rdy", arg_rdy[0], 1);

        start_op(0, {32'd16, 32'd0, 32'd0}, 1, acc);
        finish_op(0, acc, 0);

        req_q.delete();
        start_op(0, {32'd121, 32'd5, 32'd10}, 1, acc);
        finish_op(0, acc, 5);
        chk("req_cnt", req_q.size(), 3);
        if (req_q.size() == 3) begin
            chk("req0", req_q[0], 121);
            chk("req1", req_q[1], 16);
            chk("req2", req_q[2], 14);
        end

        start_op(2, {64'd0, 32'd100}, 1, acc);
        finish_op(2, acc, 0);

        start_op(1, {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1, acc);
        finish_op(1, acc, 0);

        req_q.delete();
        start_op(0, {32'd121, 32'd5, 32'd10}, 0, acc);
        t = 0;
        while (req_q.size() < 2 && t < 100) begin step(); t++; end
        chk("rst_reach_stage1", req_q.size(), 2);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("abort_arg_rdy", arg_rdy[0], 1);
        chk("abort_res_vld", res_vld[0], 0);
        nv = 0;
        repeat (25) begin step(); nv += int'(res_vld[0]); end
        chk("abort_no_res", nv, 0);

        start_op(0, {32'd121, 32'd5, 32'd10}, 1, acc);
        finish_op(0, acc, 0);

        for (int k = 0; k < 3; k++) begin
            start_op(k, {$urandom, $urandom, $urandom}, 1, acc);
            finish_op(k, acc, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
